// File: rtl/add_mul_sub_4_bit_arbiter.sv
// rtl/add_mul_sub_4_bit_arbiter.sv - round-robin arbiter sharing one 4-bit add/sub/mul ALU among three requesters
// Op codes: 00 a+b, 01 a-b, 10 b-a, 11 a*b; results are 8-bit modulo (two's complement for differences).

module add_mul_sub_4_bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       operation_1_,
  input  logic       operation_0_,
  output logic [7:0] result
);
  logic [7:0] ax;
  logic [7:0] bx;

  assign ax = {4'b0000, a};
  assign bx = {4'b0000, b};

  always_comb begin
    case ({operation_1_, operation_0_})
      2'b00:   result = ax + bx;
      2'b01:   result = ax - bx;
      2'b10:   result = bx - ax;
      default: result = ax * bx;
    endcase
  end
endmodule

module add_mul_sub_4_bit_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       req_valid,
  output logic [2:0]       req_ready,
  input  logic [11:0]      req_a,
  input  logic [11:0]      req_b,
  input  logic [5:0]       req_op,
  output logic [2:0]       resp_valid,
  input  logic [2:0]       resp_ready,
  output logic [7:0]       resp_result,
  output logic [1:0]       grant_id,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t     state;
  logic [1:0] last_grant;
  logic [1:0] lat_id;
  logic [3:0] lat_a;
  logic [3:0] lat_b;
  logic [1:0] lat_op;
  logic [7:0] alu_result;
  logic [1:0] start;
  logic [2:0] sum;
  logic [1:0] pick;
  logic       pick_valid;

  // Descending scan so the requester closest after last_grant wins.
  always_comb begin
    start      = (last_grant == 2'd2) ? 2'd0 : last_grant + 2'd1;
    pick       = 2'd0;
    pick_valid = 1'b0;
    sum        = 3'd0;
    for (int k = 2; k >= 0; k--) begin
      sum = {1'b0, start} + 3'(k);
      if (sum >= 3'd3) sum = sum - 3'd3;
      if (req_valid[sum[1:0]]) begin
        pick       = sum[1:0];
        pick_valid = 1'b1;
      end
    end
  end

  assign req_ready = (rst_n && state == IDLE && pick_valid) ? (3'b001 << pick) : 3'b000;

  add_mul_sub_4_bit u_alu (
    .a            (lat_a),
    .b            (lat_b),
    .operation_1_ (lat_op[1]),
    .operation_0_ (lat_op[0]),
    .result       (alu_result)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_grant  <= 2'd2;
      lat_id      <= 2'd0;
      lat_a       <= 4'd0;
      lat_b       <= 4'd0;
      lat_op      <= 2'd0;
      resp_result <= 8'd0;
      resp_valid  <= 3'b000;
      grant_id    <= 2'd3;
      busy        <= 1'b0;
      op_count    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            lat_a    <= req_a[{pick, 2'b00} +: 4];
            lat_b    <= req_b[{pick, 2'b00} +: 4];
            lat_op   <= req_op[{pick, 1'b0} +: 2];
            lat_id   <= pick;
            grant_id <= pick;
            busy     <= 1'b1;
            state    <= EXEC;
          end
        end
        EXEC: begin
          resp_result <= alu_result;
          resp_valid  <= 3'b001 << lat_id;
          state       <= RESP;
        end
        RESP: begin
          if (resp_ready[lat_id]) begin
            resp_valid <= 3'b000;
            grant_id   <= 2'd3;
            busy       <= 1'b0;
            last_grant <= lat_id;
            if (op_count != '1) op_count <= op_count + CNT_W'(1);
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_add_mul_sub_4_bit_arbiter.sv
// tb/tb_add_mul_sub_4_bit_arbiter.sv - randomized and directed checks of the shared-ALU arbiter against a behavioural model
// Counter width is narrowed so the exhaustive operand sweep also drives op_count into saturation.

module tb_add_mul_sub_4_bit_arbiter;
  localparam int CW   = 11;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk;
  logic          rst_n;
  logic [2:0]    req_valid;
  logic [2:0]    req_ready;
  logic [11:0]   req_a;
  logic [11:0]   req_b;
  logic [5:0]    req_op;
  logic [2:0]    resp_valid;
  logic [2:0]    resp_ready;
  logic [7:0]    resp_result;
  logic [1:0]    grant_id;
  logic          busy;
  logic [CW-1:0] op_count;

  int checks = 0;
  int errors = 0;
  int last_g = 2;
  int count  = 0;

  add_mul_sub_4_bit_arbiter #(.CNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_op      (req_op),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .grant_id    (grant_id),
    .busy        (busy),
    .op_count    (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gold(input int a, input int b, input int op);
    int r;
    case (op)
      0:       r = a + b;
      1:       r = a - b;
      2:       r = b - a;
      default: r = a * b;
    endcase
    return 8'(r);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full request/response handshake, checked cycle by cycle against the model.
  task automatic run_txn(input logic [2:0] v, input logic [11:0] a, input logic [11:0] b,
                         input logic [5:0] op, input int stall,
                         output logic [1:0] g_obs, output logic [7:0] r_obs);
    int         g;
    logic [7:0] exp_r;
    logic [2:0] oh;
    g = -1;
    for (int k = 0; k < 3; k++) begin
      int idx;
      idx = (last_g + 1 + k) % 3;
      if (g < 0 && v[idx]) g = idx;
    end
    req_valid = v; req_a = a; req_b = b; req_op = op; resp_ready = 3'b000;
    #1;
    if (g < 0) begin
      chk("idle_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      chk("idle_busy", 32'(busy), 32'd0);
      g_obs = 2'd3; r_obs = 8'd0;
      return;
    end
    oh    = 3'b001 << g;
    exp_r = gold(int'(a[4*g +: 4]), int'(b[4*g +: 4]), int'(op[2*g +: 2]));
    chk("accept_ready", 32'(req_ready), 32'(oh));
    @(posedge clk); #1;
    chk("exec_grant", 32'(grant_id), 32'(g));
    chk("exec_busy", 32'(busy), 32'd1);
    chk("exec_ready", 32'(req_ready), 32'd0);
    chk("exec_valid", 32'(resp_valid), 32'd0);
    req_a = 12'($urandom); req_b = 12'($urandom); req_op = 6'($urandom);
    @(posedge clk); #1;
    chk("resp_valid", 32'(resp_valid), 32'(oh));
    chk("resp_result", 32'(resp_result), 32'(exp_r));
    chk("resp_ready_zero", 32'(req_ready), 32'd0);
    g_obs = grant_id; r_obs = resp_result;
    for (int s = 0; s < stall; s++) begin
      resp_ready = ~oh & 3'($urandom);
      @(posedge clk); #1;
      chk("hold_valid", 32'(resp_valid), 32'(oh));
      chk("hold_result", 32'(resp_result), 32'(exp_r));
      chk("hold_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = oh | 3'($urandom);
    @(posedge clk); #1;
    resp_ready = 3'b000;
    last_g = g;
    if (count < MAXC) count++;
    chk("done_count", 32'(op_count), 32'(count));
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_grant", 32'(grant_id), 32'd3);
    chk("done_valid", 32'(resp_valid), 32'd0);
    req_valid = 3'b000;
  endtask

  initial begin
    logic [1:0]  g;
    logic [7:0]  r;
    logic [11:0] av;
    logic [11:0] bv;
    logic [5:0]  ov;
    int          exp_seq[6] = '{0, 1, 2, 0, 1, 2};

    rst_n = 1'b0; req_valid = 3'b111; req_a = 12'h0; req_b = 12'h0; req_op = 6'h0; resp_ready = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_result", 32'(resp_result), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd3);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(op_count), 32'd0);
    rst_n = 1'b1; req_valid = 3'b000;

    for (int i = 0; i < 6; i++) begin
      run_txn(3'b111, 12'($urandom), 12'($urandom), 6'($urandom), 0, g, r);
      chk("rr_order", 32'(g), 32'(exp_seq[i]));
    end

    av = 12'($urandom); bv = 12'($urandom); ov = 6'($urandom);
    av[7:4] = 4'hF; bv[7:4] = 4'hF; ov[3:2] = 2'b11;
    run_txn(3'b010, av, bv, ov, 0, g, r);
    chk("mul_grant", 32'(g), 32'd1);
    chk("mul_result", 32'(r), 32'hE1);

    run_txn(3'b001, 12'($urandom), 12'($urandom), 6'($urandom), 10, g, r);

    av = 12'($urandom); bv = 12'($urandom); ov = 6'($urandom);
    av[11:8] = 4'h3; bv[11:8] = 4'h5; ov[5:4] = 2'b11;
    run_txn(3'b100, av, bv, ov, 0, g, r);
    chk("iso_result", 32'(r), 32'h0F);

    for (int i = 0; i < 40; i++)
      run_txn(3'($urandom), 12'($urandom), 12'($urandom), 6'($urandom), int'($urandom_range(0, 3)), g, r);

    req_valid = 3'b001; req_a = 12'($urandom); req_b = 12'($urandom); req_op = 6'($urandom);
    @(posedge clk); #1;
    req_valid = 3'b000;
    @(posedge clk); #1;
    chk("pre_rst_valid", 32'(resp_valid), 32'd1);
    rst_n = 1'b0; req_valid = 3'b111;
    #1;
    chk("in_rst_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    chk("mid_rst_valid", 32'(resp_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_grant", 32'(grant_id), 32'd3);
    chk("mid_rst_count", 32'(op_count), 32'd0);
    chk("mid_rst_result", 32'(resp_result), 32'd0);
    rst_n = 1'b1; req_valid = 3'b000;
    last_g = 2; count = 0;
    run_txn(3'b100, 12'($urandom), 12'($urandom), 6'($urandom), 0, g, r);
    chk("post_rst_grant", 32'(g), 32'd2);

    for (int q = 0; q < 3; q++)
      for (int op = 0; op < 4; op++)
        for (int a = 0; a < 16; a++)
          for (int b = 0; b < 16; b++) begin
            av = 12'($urandom); bv = 12'($urandom); ov = 6'($urandom);
            av[4*q +: 4] = 4'(a); bv[4*q +: 4] = 4'(b); ov[2*q +: 2] = 2'(op);
            run_txn(3'b001 << q, av, bv, ov, 0, g, r);
          end
    chk("sat_count", 32'(op_count), 32'(MAXC));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
